// File: rtl/prio_readout_arbiter_pkg.sv
// Shared types and helpers for the priority readout arbiter.
// Holds the FSM state enum, the "no selection" code and the select-width helper.
package prio_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } state_e;

    // Truncate to the select width at the use site to get all-ones.
    localparam logic [31:0] SEL_NONE = '1;

    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prio_readout_arbiter_if.sv
// Readout handshake bundle between the block flags, the arbiter and the mux.
// master: arbiter side (drives sel_oh/sel/valid/none[/beat_cnt]); slave: consumer.
// beat_cnt and CNT_W exist only when PRIO_READOUT_STATS_EN is defined.
interface prio_readout_arbiter_if
    import prio_readout_pkg::*;
#(
    parameter int N_CH = 12
`ifdef PRIO_READOUT_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    localparam int SEL_W = sel_width(N_CH);

    logic              start;
    logic [N_CH-1:0]   has_dat;
    logic              rr_mode;
    logic              ready;
    logic [N_CH-1:0]   sel_oh;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic              none;

`ifdef PRIO_READOUT_STATS_EN
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        input  start, has_dat, rr_mode, ready,
        output sel_oh, sel, valid, none, beat_cnt
    );
    modport slave (
        output start, has_dat, rr_mode, ready,
        input  sel_oh, sel, valid, none, beat_cnt
    );
`else
    modport master (
        input  start, has_dat, rr_mode, ready,
        output sel_oh, sel, valid, none
    );
    modport slave (
        output start, has_dat, rr_mode, ready,
        input  sel_oh, sel, valid, none
    );
`endif

endinterface

// File: rtl/prio_readout_arbiter_rr_find.sv
// Rotating find-first: first set has_dat bit at or above ptr, wrapping.
// Ports: has_dat, ptr in; hit, idx (binary), oh (one-hot) out.
module prio_rr_find #(
    parameter int N_CH = 12,
    parameter int PW   = 4
) (
    input  logic [N_CH-1:0] has_dat,
    input  logic [PW-1:0]   ptr,
    output logic            hit,
    output logic [PW-1:0]   idx,
    output logic [N_CH-1:0] oh
);
    logic [N_CH-1:0] rot;
    logic [PW-1:0]   off;
    logic [PW:0]     sum;

    // rot[i] == has_dat[(ptr + i) mod N_CH]
    assign rot = N_CH'({has_dat, has_dat} >> ptr);

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = PW'(i);
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= (PW + 1)'(N_CH)) ? PW'(sum - (PW + 1)'(N_CH)) : PW'(sum);
    assign oh  = hit ? (N_CH'(1) << idx) : '0;

endmodule

// File: rtl/prio_readout_arbiter.sv
// Picks the next non-empty memory block and holds it for a burst of beats.
// Ports: clk, reset (async, active-high), bus (master modport of the handshake).
// Optional PRIO_READOUT_STATS_EN adds a saturating accepted-beat counter.
module prio_readout_arbiter
    import prio_readout_pkg::*;
#(
    parameter int N_CH      = 12,
    parameter int MAX_BURST = 8
`ifdef PRIO_READOUT_STATS_EN
    , parameter int CNT_W   = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    prio_readout_arbiter_if.master bus
);
    localparam int SEL_W = sel_width(N_CH);
    localparam int PW    = $clog2(N_CH);
    localparam int BW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0]    LAST   = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [SEL_W-1:0] NO_SEL = SEL_NONE[SEL_W-1:0];
    localparam logic [PW-1:0]    TOP    = PW'(N_CH - 1);

    state_e           state;
    logic             grant_q;
    logic             mode_q;
    logic             none_q;
    logic [N_CH-1:0]  sel_oh_q;
    logic [SEL_W-1:0] sel_q;
    logic [PW-1:0]    rr_ptr;
    logic [BW-1:0]    burst_cnt;

    logic [PW-1:0]    find_ptr;
    logic [PW-1:0]    find_idx;
    logic [N_CH-1:0]  find_oh;
    logic             find_hit;
    logic [PW-1:0]    cur;
    logic             sel_has;
    logic             beat;
    logic             burst_end;

    // Fixed priority is a rotating search that always starts at block 0.
    assign find_ptr = bus.rr_mode ? rr_ptr : '0;

    prio_rr_find #(
        .N_CH (N_CH),
        .PW   (PW)
    ) u_find (
        .has_dat (bus.has_dat),
        .ptr     (find_ptr),
        .hit     (find_hit),
        .idx     (find_idx),
        .oh      (find_oh)
    );

    // sel_oh is zero without a grant, so this also covers the no-grant case.
    assign sel_has   = |(bus.has_dat & sel_oh_q);
    assign beat      = grant_q & sel_has & bus.ready;
    assign burst_end = (MAX_BURST != 0) && (burst_cnt == LAST);
    assign cur       = sel_q[PW-1:0];

    assign bus.sel_oh = sel_oh_q;
    assign bus.sel    = sel_q;
    assign bus.valid  = grant_q & sel_has;
    assign bus.none   = none_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= 1'b0;
            mode_q    <= 1'b0;
            none_q    <= 1'b0;
            sel_oh_q  <= '0;
            sel_q     <= NO_SEL;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (bus.start) begin
            state     <= ARB;
            grant_q   <= 1'b0;
            sel_oh_q  <= '0;
            sel_q     <= NO_SEL;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: ;
                ARB: begin
                    if (find_hit) begin
                        state     <= GRANT;
                        grant_q   <= 1'b1;
                        mode_q    <= bus.rr_mode;
                        none_q    <= 1'b0;
                        sel_oh_q  <= find_oh;
                        sel_q     <= SEL_W'(find_idx);
                        burst_cnt <= '0;
                    end else begin
                        none_q <= 1'b1;
                        sel_q  <= NO_SEL;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if ((beat && burst_end) || !sel_has) begin
                        state    <= ARB;
                        grant_q  <= 1'b0;
                        sel_oh_q <= '0;
                        sel_q    <= NO_SEL;
                        if (mode_q) begin
                            rr_ptr <= (cur == TOP) ? '0 : cur + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRIO_READOUT_STATS_EN
    logic [CNT_W-1:0] beat_cnt;

    // A beat in the start cycle is accepted downstream but not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (bus.start) begin
            beat_cnt <= '0;
        end else if (beat && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign bus.beat_cnt = beat_cnt;
`endif

endmodule
